seq_detect: RTL and testbench
=============================

Name: seq_detect

Overview:
- Parametrised serial pattern-detector FSM. It is the next generation of the team's single-bit toggle state machine.
- Consumes one qualified bit per cycle on din. Tracks how many leading pattern bits are currently matched, and pulses match when the full PATTERN is seen.
- Optional overlap detection and an optional saturating match counter.
- Sits behind serial front-ends; its state output also feeds functional-coverage collection.

Parameters:
- PAT_W, 4: pattern length in bits. Legal range 2..16.
- PATTERN, 4'b1011: target sequence. PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = search restarts from empty after each match.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous clear of state, match and counter.
- din_valid  in  1  qualifies din for this cycle.
- din  in  1  serial data bit.
- match  out  1  one-cycle pulse when the pattern completes; registered.
- state_o  out  $clog2(PAT_W)  current matched-prefix length, 0..PAT_W-1.
- match_cnt  out  CNT_W  saturating count of matches.
- cnt_sat  out  1  high while match_cnt equals its all-ones value.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. With rst high, state_o=0, match=0, match_cnt=0 and cnt_sat=0 immediately, independent of clk.
- State meaning: state k means the last k accepted bits equal PATTERN[PAT_W-1 -: k].
- Legal states are 0..PAT_W-1. Any other encoding forces next state 0.
- din_valid=0: state holds, match=0 next cycle, counter holds.
- din_valid=1, state k, din equals expected bit PATTERN[PAT_W-1-k]:
  - If k<PAT_W-1, next state k+1.
  - If k=PAT_W-1, this is a completion: match=1 in the next cycle.
  - After a completion, next state = F(PAT_W) when OVERLAP=1, else 0.
  - F(n) is the longest proper prefix of PATTERN that is also a suffix of its first n bits.
- din_valid=1, mismatch: next state = longest prefix of PATTERN that is a suffix of (accepted prefix + din). This is the KMP transition and is never forced to 0 unless no prefix fits.
- Latency: match rises exactly one cycle after the clk edge that sampled the final bit. It is never asserted two cycles from a single completion.
- clear (synchronous) has priority over din_valid. It sets state 0, match 0 and counter 0 on the next edge, even if the same cycle carries a completing bit.
- Counter:
  - Increments by 1 on each completion.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat is high whenever the count equals all-ones.
  - match pulses continue after saturation.
- Transition table: computed at elaboration from PATTERN. No runtime pattern load.
- rst asserted mid-pattern: partial progress is discarded; detection restarts from state 0 after release.

Optional Feature:
- SEQ_DETECT_CNT_EN defined: match_cnt and cnt_sat are implemented as above.
- SEQ_DETECT_CNT_EN not defined: counter logic is removed, and match_cnt and cnt_sat are tied to 0. All other behaviour is unchanged.

Decomposition:
- Package seq_detect_pkg holds:
  - state typedef sized by $clog2(PAT_W);
  - constant function next_state(pattern, pat_w, k, bit) implementing the KMP transition;
  - constant function fallback(pattern, pat_w).
- Sub-module seq_detect_cnt: saturating counter with inc, clear and async rst inputs; outputs count and sat. Instantiated only under SEQ_DETECT_CNT_EN.

Test Plan (PAT_W=4, PATTERN=1011, CNT_W=8 unless noted):
- OVERLAP=1, din_valid=1, bits 1,0,1,1,0,1,1 -> match pulses one cycle after bit 4 and after bit 7; match_cnt=2.
- OVERLAP=0, same stream -> single match after bit 4, none after bit 7; match_cnt=1.
- Fallback: bits 1,0,1,0,1,1 -> state_o goes 1,2,3,2,3, then match after bit 6; never passes through state 0.
- Gaps: bits 1,0 then din_valid=0 for 5 cycles with din toggling, then 1,1 -> state holds at 2 during gap; one match.
- Simultaneous events: clear=1 in the cycle of the completing bit -> no match pulse, state_o=0, match_cnt unchanged at 0. Also assert rst asynchronously at state 3 -> state_o=0 before the next edge.
- CNT_W=2, 4 completions -> match_cnt 1,2,3,3; cnt_sat high from the third match; fourth match still pulses. Without SEQ_DETECT_CNT_EN, match_cnt and cnt_sat stay 0 throughout.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the seq_detect pattern FSM.
// The KMP transition table is built from these constant functions.
package seq_detect_pkg;

  localparam int MAX_PAT_W = 16;

  // Wide enough for any legal pattern length; the top slices it to $clog2(PAT_W).
  typedef logic [$clog2(MAX_PAT_W)-1:0] state_t;

  // Longest proper prefix of the pattern that is a suffix of the matched
  // prefix of length k followed by bit b. Pattern bit pat_w-1 is received first.
  function automatic state_t next_state(input logic [MAX_PAT_W-1:0] pattern,
                                        input int pat_w, input int k, input logic b);
    int   best;
    int   j;
    logic ok;
    logic s_bit;
    best = 0;
    for (int len = 1; len < pat_w; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++) begin
          j     = k + 1 - len + i;
          s_bit = (j == k) ? b : pattern[pat_w-1-j];
          if (s_bit != pattern[pat_w-1-i]) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return state_t'(best);
  endfunction

  // Restart state after a full match when overlapping matches are allowed.
  function automatic state_t fallback(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
    return next_state(pattern, pat_w, pat_w - 1, pattern[0]);
  endfunction

endpackage

// File: rtl/seq_detect_cnt.sv
// Saturating event counter for seq_detect; sat is high while the count is all-ones.
module seq_detect_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] r_count;

  assign sat   = &r_count;
  assign count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && !sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial KMP pattern detector with registered match pulse and matched-prefix state.
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise it is tied to 0.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     din_valid,
  input  logic                     din,
  output logic                     match,
  output logic [$clog2(PAT_W)-1:0] state_o,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat
);

  localparam int                   SW      = $clog2(PAT_W);
  localparam int                   NSTATE  = 2 ** SW;
  localparam logic [SW-1:0]        LAST    = SW'(PAT_W - 1);
  localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
  localparam logic [SW-1:0]        RESTART = OVERLAP ? SW'(fallback(PAT_EXT, PAT_W)) : '0;

  logic [SW-1:0] r_state;
  logic          r_match;
  logic [SW-1:0] w_next0 [NSTATE];
  logic [SW-1:0] w_next1 [NSTATE];
  logic          w_legal [NSTATE];
  logic          w_complete;

  // Transition table per state and input bit; unused encodings all lead to 0.
  for (genvar k = 0; k < NSTATE; k++) begin : g_tbl
    if (k < PAT_W) begin : g_legal
      localparam logic          EXP    = PATTERN[PAT_W-1-k];
      localparam logic [SW-1:0] N_HIT  = (k == PAT_W - 1) ? RESTART : SW'(k + 1);
      localparam logic [SW-1:0] N_MISS = SW'(next_state(PAT_EXT, PAT_W, k, !EXP));
      assign w_next0[k] = EXP ? N_MISS : N_HIT;
      assign w_next1[k] = EXP ? N_HIT : N_MISS;
      assign w_legal[k] = 1'b1;
    end else begin : g_illegal
      assign w_next0[k] = '0;
      assign w_next1[k] = '0;
      assign w_legal[k] = 1'b0;
    end
  end

  assign w_complete = din_valid && (r_state == LAST) && (din == PATTERN[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_match <= 1'b0;
    end else if (clear) begin
      r_state <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_complete;
      if (!w_legal[r_state]) begin
        r_state <= '0;
      end else if (din_valid) begin
        r_state <= din ? w_next1[r_state] : w_next0[r_state];
      end
    end
  end

  assign match   = r_match;
  assign state_o = r_state;

`ifdef SEQ_DETECT_CNT_EN
  seq_detect_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (w_complete),
    .count(match_cnt),
    .sat  (cnt_sat)
  );
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect: three instances (overlap, non-overlap, 2-bit counter) share stimulus
// and are compared against a history-based model of the matched-prefix rules.
module tb_seq_detect;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int       PAT_W = 4;
  localparam bit [3:0] PAT   = 4'b1011;

  logic clk = 1'b0;
  logic rst, clear, din_valid, din;

  logic [1:0] st_ov, st_no, st_c2;
  logic       m_ov, m_no, m_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;
  logic       sat_ov, sat_no, sat_c2;

  int n_run  = 0;
  int n_fail = 0;

  // Model: accepted-bit history since reset/clear (non-overlap history also restarts after a match).
  bit         q_ov[$];
  bit         q_no[$];
  logic [1:0] ms_ov, ms_no;
  logic       mm_ov, mm_no;
  int         mc_ov, mc_no, mc_c2;

  always #5 clk = ~clk;

  seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din),
    .match(m_ov), .state_o(st_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov));

  seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din),
    .match(m_no), .state_o(st_no), .match_cnt(cnt_no), .cnt_sat(sat_no));

  seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .clear(clear), .din_valid(din_valid), .din(din),
    .match(m_c2), .state_o(st_c2), .match_cnt(cnt_c2), .cnt_sat(sat_c2));

  function automatic bit suffix_is_prefix(input bit q[$], input int len);
    if (q.size() < len) return 1'b0;
    for (int i = 0; i < len; i++)
      if (q[q.size()-len+i] != PAT[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int prefix_len(input bit q[$]);
    for (int len = PAT_W - 1; len > 0; len--)
      if (suffix_is_prefix(q, len)) return len;
    return 0;
  endfunction

  task automatic model_reset();
    q_ov.delete(); q_no.delete();
    ms_ov = 2'd0; ms_no = 2'd0; mm_ov = 1'b0; mm_no = 1'b0;
    mc_ov = 0; mc_no = 0; mc_c2 = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      q_ov.push_back(d);
      q_no.push_back(d);
      mm_ov = suffix_is_prefix(q_ov, PAT_W);
      mm_no = suffix_is_prefix(q_no, PAT_W);
      if (mm_ov) begin
        if (mc_ov < 255) mc_ov++;
        if (mc_c2 < 3) mc_c2++;
      end
      if (mm_no) begin
        if (mc_no < 255) mc_no++;
        q_no.delete();
      end
      while (q_ov.size() > PAT_W) void'(q_ov.pop_front());
      while (q_no.size() > PAT_W) void'(q_no.pop_front());
    end else begin
      mm_ov = 1'b0;
      mm_no = 1'b0;
    end
    ms_ov = 2'(prefix_len(q_ov));
    ms_no = 2'(prefix_len(q_no));
  endtask

  // Called at posedge+1; drives inputs, advances the model, returns at next posedge+1.
  task automatic cycle(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clear = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; din_valid = 1'b0; din = 1'b0;
    #2;
    n_run++; if (st_ov !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", st_ov); end
    n_run++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0d exp 0", m_ov); end
    n_run++; if (cnt_ov !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", cnt_ov); end
    n_run++; if (sat_c2 !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0d exp 0", sat_c2); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_overlap();
    bit b[7]      = '{1, 0, 1, 1, 0, 1, 1};
    bit exp_ov[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit exp_no[7] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, b[i], 1'b0);
      n_run++; if (m_ov !== exp_ov[i]) begin n_fail++; $display("FAIL ovl_match bit %0d: got %0d exp %0d", i + 1, m_ov, exp_ov[i]); end
      n_run++; if (m_no !== exp_no[i]) begin n_fail++; $display("FAIL novl_match bit %0d: got %0d exp %0d", i + 1, m_no, exp_no[i]); end
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_run++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL ovl_single_pulse: got %0d exp 0", m_ov); end
    n_run++; if (cnt_ov !== (CNT_EN ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL ovl_cnt: got %0d exp %0d", cnt_ov, CNT_EN ? 2 : 0); end
    n_run++; if (cnt_no !== (CNT_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL novl_cnt: got %0d exp %0d", cnt_no, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_fallback();
    bit         b[6]  = '{1, 0, 1, 0, 1, 1};
    logic [1:0] es[6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    bit         em[6] = '{0, 0, 0, 0, 0, 1};
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, b[i], 1'b0);
      n_run++; if (st_ov !== es[i]) begin n_fail++; $display("FAIL fallback_state bit %0d: got %0d exp %0d", i + 1, st_ov, es[i]); end
      n_run++; if (m_ov !== em[i]) begin n_fail++; $display("FAIL fallback_match bit %0d: got %0d exp %0d", i + 1, m_ov, em[i]); end
    end
  endtask

  task automatic test_gap();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, i[0], 1'b0);
      n_run++; if (st_ov !== 2'd2) begin n_fail++; $display("FAIL gap_hold cyc %0d: got %0d exp 2", i, st_ov); end
      n_run++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL gap_match cyc %0d: got %0d exp 0", i, m_ov); end
    end
    cycle(1'b1, 1'b1, 1'b0);
    n_run++; if (st_ov !== 2'd3) begin n_fail++; $display("FAIL gap_resume: got %0d exp 3", st_ov); end
    cycle(1'b1, 1'b1, 1'b0);
    n_run++; if (m_ov !== 1'b1) begin n_fail++; $display("FAIL gap_match_end: got %0d exp 1", m_ov); end
  endtask

  task automatic test_clear_rst();
    bit b[6] = '{1, 0, 1, 1, 0, 1};
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    n_run++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL clear_match: got %0d exp 0", m_ov); end
    n_run++; if (st_ov !== 2'd0) begin n_fail++; $display("FAIL clear_state: got %0d exp 0", st_ov); end
    n_run++; if (cnt_ov !== 8'd0) begin n_fail++; $display("FAIL clear_cnt: got %0d exp 0", cnt_ov); end
    for (int i = 0; i < 6; i++) cycle(1'b1, b[i], 1'b0);
    n_run++; if (st_ov !== 2'd3) begin n_fail++; $display("FAIL pre_rst_state: got %0d exp 3", st_ov); end
    n_run++; if (cnt_ov !== (CNT_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d exp %0d", cnt_ov, CNT_EN ? 1 : 0); end
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_run++; if (st_ov !== 2'd0) begin n_fail++; $display("FAIL async_rst_state: got %0d exp 0", st_ov); end
    n_run++; if (cnt_ov !== 8'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d exp 0", cnt_ov); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0);
    n_run++; if (st_ov !== 2'd1) begin n_fail++; $display("FAIL post_rst_state: got %0d exp 1", st_ov); end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    n_run++; if (m_ov !== 1'b1) begin n_fail++; $display("FAIL post_rst_match: got %0d exp 1", m_ov); end
  endtask

  task automatic test_saturation();
    logic [1:0] ec[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    cycle(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) cycle(1'b1, PAT[i], 1'b0);
      n_run++; if (m_c2 !== 1'b1) begin n_fail++; $display("FAIL sat_match %0d: got %0d exp 1", r + 1, m_c2); end
      n_run++; if (cnt_c2 !== (CNT_EN ? ec[r] : 2'd0)) begin n_fail++; $display("FAIL sat_cnt %0d: got %0d exp %0d", r + 1, cnt_c2, CNT_EN ? ec[r] : 2'd0); end
      n_run++; if (sat_c2 !== (CNT_EN && r >= 2)) begin n_fail++; $display("FAIL sat_flag %0d: got %0d exp %0d", r + 1, sat_c2, CNT_EN && r >= 2); end
    end
  endtask

  task automatic test_random();
    bit v, d, c;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 59) == 0);
      cycle(v, d, c);
      n_run++; if (st_ov !== ms_ov) begin n_fail++; $display("FAIL rnd_state_ov cyc %0d: got %0d exp %0d", i, st_ov, ms_ov); end
      n_run++; if (m_ov !== mm_ov) begin n_fail++; $display("FAIL rnd_match_ov cyc %0d: got %0d exp %0d", i, m_ov, mm_ov); end
      n_run++; if (st_no !== ms_no) begin n_fail++; $display("FAIL rnd_state_no cyc %0d: got %0d exp %0d", i, st_no, ms_no); end
      n_run++; if (m_no !== mm_no) begin n_fail++; $display("FAIL rnd_match_no cyc %0d: got %0d exp %0d", i, m_no, mm_no); end
      n_run++; if (st_c2 !== ms_ov || m_c2 !== mm_ov) begin n_fail++; $display("FAIL rnd_c2_fsm cyc %0d: got %0d/%0d exp %0d/%0d", i, st_c2, m_c2, ms_ov, mm_ov); end
      n_run++; if (cnt_ov !== (CNT_EN ? 8'(mc_ov) : 8'd0)) begin n_fail++; $display("FAIL rnd_cnt_ov cyc %0d: got %0d exp %0d", i, cnt_ov, CNT_EN ? mc_ov : 0); end
      n_run++; if (cnt_no !== (CNT_EN ? 8'(mc_no) : 8'd0)) begin n_fail++; $display("FAIL rnd_cnt_no cyc %0d: got %0d exp %0d", i, cnt_no, CNT_EN ? mc_no : 0); end
      n_run++; if (cnt_c2 !== (CNT_EN ? 2'(mc_c2) : 2'd0)) begin n_fail++; $display("FAIL rnd_cnt_c2 cyc %0d: got %0d exp %0d", i, cnt_c2, CNT_EN ? mc_c2 : 0); end
      n_run++; if (sat_c2 !== (CNT_EN && mc_c2 == 3)) begin n_fail++; $display("FAIL rnd_sat_c2 cyc %0d: got %0d exp %0d", i, sat_c2, CNT_EN && mc_c2 == 3); end
      n_run++; if ({sat_ov, sat_no} !== {CNT_EN && mc_ov == 255, CNT_EN && mc_no == 255}) begin n_fail++; $display("FAIL rnd_sat8 cyc %0d: got %0b%0b", i, sat_ov, sat_no); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_fallback();
    test_gap();
    test_clear_rst();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
